// File: rtl/ascii_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ascii_write_arbiter
// Description : Three-way write arbiter in front of the ASCII controller.
//               Requester 0 is the register renderer, 1 the memory renderer
//               and 2 CPU stdout. In IDLE a round-robin search picks one
//               requester per cycle. A winner that also holds its lock bit
//               keeps the port (OWN) for up to MAX_BURST consecutive writes.
//               The accepted write is registered, so it is issued one cycle
//               after the accept.
// Ports       : clk                 - system clock, all state on posedge
//               rst                 - asynchronous active-low reset
//               req[2:0]            - per-requester write request
//               lock[2:0]           - per-requester burst-hold request
//               req_addr            - flattened addresses, i at [i*ADDR_W +: ADDR_W]
//               req_data            - flattened data, i at [i*DATA_W +: DATA_W]
//               gnt[2:0]            - combinational one-hot accept
//               ascii_write_en      - registered write strobe
//               ascii_write_address - registered write address
//               ascii_input         - registered write data
//               owner[1:0]          - current burst owner, 3 when none
//               busy                - high while a burst owns the port
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_write_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req,
    input  logic [2:0]          lock,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*DATA_W-1:0] req_data,
    output logic [2:0]          gnt,
    output logic                ascii_write_en,
    output logic [ADDR_W-1:0]   ascii_write_address,
    output logic [DATA_W-1:0]   ascii_input,
    output logic [1:0]          owner,
    output logic                busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam logic [1:0] c_no_owner  = 2'd3;
    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_last;
    logic [1:0]        w_last_nxt;
    logic [1:0]        r_owner;
    logic [1:0]        w_owner_nxt;
    logic [7:0]        r_count;
    logic [7:0]        w_count_nxt;
    logic [7:0]        w_count_inc;
    logic [2:0]        w_rr_gnt;
    logic [2:0]        w_own_gnt;
    logic [2:0]        w_gnt;
    logic [1:0]        w_gnt_idx;
    logic              w_xfer;
    logic              r_write_en;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_sel_data;

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_rr_gnt = 3'b000;
        case (r_last)
            2'd0: begin
                if (req[1])      w_rr_gnt = 3'b010;
                else if (req[2]) w_rr_gnt = 3'b100;
                else if (req[0]) w_rr_gnt = 3'b001;
            end
            2'd1: begin
                if (req[2])      w_rr_gnt = 3'b100;
                else if (req[0]) w_rr_gnt = 3'b001;
                else if (req[1]) w_rr_gnt = 3'b010;
            end
            default: begin
                if (req[0])      w_rr_gnt = 3'b001;
                else if (req[1]) w_rr_gnt = 3'b010;
                else if (req[2]) w_rr_gnt = 3'b100;
            end
        endcase
    end

    // In OWN only the owner can be accepted; r_owner is 0..2 in this state.
    assign w_own_gnt = req & (3'b001 << r_owner);
    assign w_gnt     = (r_state == ST_OWN) ? w_own_gnt : w_rr_gnt;

    // gnt is combinational, so it must be masked while reset is held.
    assign gnt    = w_gnt & {3{rst}};
    assign w_xfer = |gnt;

    always_comb begin
        case (gnt)
            3'b010:  w_gnt_idx = 2'd1;
            3'b100:  w_gnt_idx = 2'd2;
            default: w_gnt_idx = 2'd0;
        endcase
    end

    always_comb begin
        case (w_gnt_idx)
            2'd1: begin
                w_sel_addr = req_addr[1*ADDR_W +: ADDR_W];
                w_sel_data = req_data[1*DATA_W +: DATA_W];
            end
            2'd2: begin
                w_sel_addr = req_addr[2*ADDR_W +: ADDR_W];
                w_sel_data = req_data[2*DATA_W +: DATA_W];
            end
            default: begin
                w_sel_addr = req_addr[0 +: ADDR_W];
                w_sel_data = req_data[0 +: DATA_W];
            end
        endcase
    end

    assign w_count_inc = r_count + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_last_nxt = w_gnt_idx;
                    // With a burst cap of 1 the entry write already exhausts
                    // the burst, so ownership is never taken.
                    if (lock[w_gnt_idx] && (c_max_burst > 8'd1)) begin
                        w_state_nxt = ST_OWN;
                        w_owner_nxt = w_gnt_idx;
                        w_count_nxt = 8'd1;
                    end
                end
            end
            ST_OWN: begin
                if (w_xfer) begin
                    w_count_nxt = w_count_inc;
                end
                // Releasing on lock drop still lets a same-edge write through.
                if (!lock[r_owner] || (w_xfer && (w_count_inc == c_max_burst))) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = c_no_owner;
                    w_last_nxt  = r_owner;
                    w_count_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 2'd2;
            r_owner    <= c_no_owner;
            r_count    <= 8'd0;
            r_write_en <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_owner    <= w_owner_nxt;
            r_count    <= w_count_nxt;
            r_write_en <= w_xfer;
            if (w_xfer) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    assign ascii_write_en      = r_write_en;
    assign ascii_write_address = r_addr;
    assign ascii_input         = r_data;
    assign owner               = r_owner;
    assign busy                = (r_state == ST_OWN);

endmodule
`default_nettype wire
